// File: rtl/i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regs
// Purpose  : I2C target with an internal 8-bit register file. SCL/SDA are
//            oversampled on clk; START, repeated START and STOP are detected
//            from the synchronised lines. A write transaction carries a
//            register pointer byte followed by data bytes. A read transaction
//            streams registers starting at the current pointer. The pointer
//            auto-increments and wraps from NUM_REGS-1 to 0.
// Ports    : clk, rst        - system clock, async active-high reset
//            scl_i, sda_i    - bus line levels
//            sda_oe          - 1 pulls SDA low, 0 releases it
//            busy            - address-matched transaction in progress
//            wr_strobe       - one-cycle pulse per register written from bus
//            wr_addr/wr_data - index/byte of that write
//            loc_addr        - local read index
//            loc_rdata       - combinational regs[loc_addr]
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             busy,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] loc_addr,
    output logic [7:0]       loc_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_PTR    = 3'd2,
        S_WDATA  = 3'd3,
        S_RDATA  = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: two synchroniser flops plus one history flop.
    // Reset to 1 (idle bus level) so no spurious edge is seen on release.
    // ------------------------------------------------------------------
    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl_i;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda_i;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

    // ------------------------------------------------------------------
    // State and datapath registers
    // r_cnt counts SCL rises within a byte: 1..8 are data bits, 9 marks
    // that the ACK slot has been sampled. Falls with r_cnt==8 open the ACK
    // slot; falls with r_cnt==9 close it.
    // ------------------------------------------------------------------
    state_t             r_state, w_state_n;
    logic [3:0]         r_cnt, w_cnt_n;
    logic               r_oe, w_oe_n;
    logic               r_busy, w_busy_n;
    logic [7:0]         r_shift, w_shift_n;
    logic [7:0]         r_tx, w_tx_n;
    logic [PTR_W-1:0]   r_ptr, w_ptr_n;
    logic               r_first, w_first_n;   // next ACK-slot close starts a read
    logic               r_mack, w_mack_n;     // SDA level sampled in the ACK slot
    logic               w_we;
    logic               r_wr_strobe;
    logic [PTR_W-1:0]   r_wr_addr;
    logic [7:0]         r_wr_data;
    logic [7:0]         r_regs [NUM_REGS];

    logic [PTR_W-1:0]   w_ptr_inc;
    assign w_ptr_inc = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_oe_n    = r_oe;
        w_busy_n  = r_busy;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        w_ptr_n   = r_ptr;
        w_first_n = r_first;
        w_mack_n  = r_mack;
        w_we      = 1'b0;

        if (w_stop) begin
            w_state_n = S_IDLE;
            w_cnt_n   = 4'd0;
            w_oe_n    = 1'b0;
            w_busy_n  = 1'b0;
        end else if (w_start) begin
            // Covers repeated START; busy is kept until the STOP.
            w_state_n = S_ADDR;
            w_cnt_n   = 4'd0;
            w_oe_n    = 1'b0;
        end else if (w_scl_rise) begin
            if (r_state != S_IDLE && r_state != S_IGNORE) begin
                if (r_cnt < 4'd8) begin
                    w_shift_n = {r_shift[6:0], r_sda_sync};
                    w_cnt_n   = r_cnt + 4'd1;
                end else if (r_cnt == 4'd8) begin
                    w_mack_n = r_sda_sync;
                    w_cnt_n  = 4'd9;
                end
            end
        end else if (w_scl_fall) begin
            case (r_state)
                S_ADDR: begin
                    if (r_cnt == 4'd8) begin
                        if (r_shift[7:1] == DEV_ADDR) begin
                            w_oe_n    = 1'b1;
                            w_busy_n  = 1'b1;
                            w_first_n = 1'b1;
                            w_state_n = r_shift[0] ? S_RDATA : S_PTR;
                        end else begin
                            w_state_n = S_IGNORE;
                        end
                    end
                end
                S_PTR: begin
                    if (r_cnt == 4'd8) begin
                        if ({1'b0, r_shift} < 9'(NUM_REGS)) begin
                            w_oe_n    = 1'b1;
                            w_ptr_n   = r_shift[PTR_W-1:0];
                            w_state_n = S_WDATA;
                        end else begin
                            w_state_n = S_IGNORE;
                        end
                    end else if (r_cnt == 4'd9) begin
                        w_oe_n  = 1'b0;
                        w_cnt_n = 4'd0;
                    end
                end
                S_WDATA: begin
                    if (r_cnt == 4'd8) begin
                        w_oe_n  = 1'b1;
                        w_we    = 1'b1;
                        w_ptr_n = w_ptr_inc;
                    end else if (r_cnt == 4'd9) begin
                        w_oe_n  = 1'b0;
                        w_cnt_n = 4'd0;
                    end
                end
                S_RDATA: begin
                    if (r_cnt >= 4'd1 && r_cnt <= 4'd7) begin
                        w_tx_n = {r_tx[6:0], 1'b0};
                        w_oe_n = ~r_tx[6];
                    end else if (r_cnt == 4'd8) begin
                        w_oe_n = 1'b0;          // master owns the ACK slot
                    end else if (r_cnt == 4'd9) begin
                        w_cnt_n = 4'd0;
                        if (r_first) begin
                            // First byte after the address ACK: no increment.
                            w_first_n = 1'b0;
                            w_tx_n    = r_regs[r_ptr];
                            w_oe_n    = ~r_regs[r_ptr][7];
                        end else if (!r_mack) begin
                            w_ptr_n = w_ptr_inc;
                            w_tx_n  = r_regs[w_ptr_inc];
                            w_oe_n  = ~r_regs[w_ptr_inc][7];
                        end else begin
                            w_oe_n    = 1'b0;
                            w_state_n = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: begin
                    w_oe_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_shift     <= 8'h00;
            r_tx        <= 8'h00;
            r_ptr       <= '0;
            r_first     <= 1'b0;
            r_mack      <= 1'b1;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_cnt       <= w_cnt_n;
            r_oe        <= w_oe_n;
            r_busy      <= w_busy_n;
            r_shift     <= w_shift_n;
            r_tx        <= w_tx_n;
            r_ptr       <= w_ptr_n;
            r_first     <= w_first_n;
            r_mack      <= w_mack_n;
            r_wr_strobe <= w_we;
            if (w_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= r_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_we) begin
            r_regs[r_ptr] <= r_shift;
        end
    end

    assign sda_oe    = r_oe;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign loc_rdata = (32'(loc_addr) < NUM_REGS) ? r_regs[loc_addr] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regs
// Purpose  : Bus-level bench for i2c_slave_regs. A bit-banged I2C master
//            drives SCL/SDA (wired-AND with the target's pull-down) and a
//            transaction-level model of the register file and pointer
//            predicts ACKs, read data and register writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regs;

    localparam int         NREG = 16;
    localparam logic [6:0] DEV  = 7'h50;
    localparam int         Q    = 6;    // clk per quarter SCL period

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl   = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_rdata;

    assign sda_line = m_sda & ~sda_oe;

    i2c_slave_regs #(.DEV_ADDR(DEV), .NUM_REGS(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         stable    = 1'b0;   // model and DUT register file agree now
    bit         exp_quiet = 1'b0;   // target must stay off the bus
    logic [7:0] mdl_regs [NREG];
    int         mdl_ptr = 0;
    int         q_addr [$];
    logic [7:0] q_data [$];
    logic [7:0] rd_buf [4];

    function automatic int wrap(input int p);
        return (p == NREG - 1) ? 0 : p + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    int         mon_ea;
    logic [7:0] mon_ed;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (wr_strobe) begin
                n_tests++;
                if (q_addr.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_strobe_unexpected: got addr=%0d data=%02h, required no strobe", wr_addr, wr_data);
                end else begin
                    mon_ea = q_addr.pop_front();
                    mon_ed = q_data.pop_front();
                    if (int'(wr_addr) != mon_ea || wr_data !== mon_ed) begin
                        n_fail++;
                        $display("FAIL wr_strobe_write: got (%0d,%02h), required (%0d,%02h)", wr_addr, wr_data, mon_ea, mon_ed);
                    end
                end
            end
            if (exp_quiet) begin
                n_tests++;
                if (sda_oe !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL quiet_bus: got sda_oe=%b busy=%b, required 0 0", sda_oe, busy);
                end
            end
            if (stable) begin
                n_tests++;
                if (loc_rdata !== mdl_regs[loc_addr]) begin
                    n_fail++;
                    $display("FAIL loc_rdata[%0d]: got %02h, required %02h", loc_addr, loc_rdata, mdl_regs[loc_addr]);
                end
            end
        end
    end

    // ---------------- bit-level master ----------------
    task automatic bus_bit(input logic b, output logic sampled);
        repeat (Q) @(negedge clk); m_sda = b;
        repeat (Q) @(negedge clk); scl = 1'b1;
        repeat (Q) @(negedge clk); sampled = sda_line;
        repeat (Q) @(negedge clk); scl = 1'b0;
    endtask

    task automatic bus_start();
        repeat (Q) @(negedge clk); m_sda = 1'b1;
        repeat (Q) @(negedge clk); scl = 1'b1;
        repeat (Q) @(negedge clk); m_sda = 1'b0;
        repeat (Q) @(negedge clk); scl = 1'b0;
    endtask

    task automatic bus_stop();
        repeat (Q) @(negedge clk); m_sda = 1'b0;
        repeat (Q) @(negedge clk); scl = 1'b1;
        repeat (Q) @(negedge clk); m_sda = 1'b1;
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic bus_rbyte(input bit mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    task automatic sweep_loc();
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk); loc_addr = 4'(i);
        end
        @(negedge clk);
    endtask

    task automatic loc_chk(input string name, input int idx, input logic [7:0] exp);
        @(negedge clk); loc_addr = 4'(idx);
        @(posedge clk); #1;
        chk(name, loc_rdata, exp);
    endtask

    task automatic finish_txn();
        repeat (4) @(negedge clk);
        chk("busy_after_stop", busy, 0);
        chk("pending_writes", q_addr.size(), 0);
        q_addr.delete();
        q_data.delete();
        exp_quiet = 1'b0;
        stable    = 1'b1;
        sweep_loc();
    endtask

    // ---------------- transaction-level model + stimulus ----------------
    task automatic do_write(input logic [7:0] ab, input logic [7:0] p, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic       a;
        logic [7:0] d [3];
        bit         match, pok;
        d[0] = d0; d[1] = d1; d[2] = d2;
        match     = (ab[7:1] == DEV) && !ab[0];
        pok       = match && (p < NREG);
        stable    = 1'b0;
        exp_quiet = (ab[7:1] != DEV);
        bus_start();
        bus_wbyte(ab, a);
        chk("addr_ack", a, match);
        chk("busy_after_addr", busy, match);
        bus_wbyte(p, a);
        chk("ptr_ack", a, pok);
        if (pok) mdl_ptr = int'(p);
        for (int k = 0; k < n; k++) begin
            if (pok) begin
                q_addr.push_back(mdl_ptr);
                q_data.push_back(d[k]);
            end
            bus_wbyte(d[k], a);
            chk("data_ack", a, pok);
            if (pok) begin
                mdl_regs[mdl_ptr] = d[k];
                mdl_ptr = wrap(mdl_ptr);
            end
        end
        bus_stop();
        finish_txn();
    endtask

    task automatic do_read(input bit with_ptr, input logic [7:0] p, input int n);
        logic       a;
        logic [7:0] b;
        bit         pok;
        stable = 1'b0;
        bus_start();
        if (with_ptr) begin
            bus_wbyte({DEV, 1'b0}, a);
            chk("rd_waddr_ack", a, 1);
            bus_wbyte(p, a);
            pok = (p < NREG);
            chk("rd_ptr_ack", a, pok);
            if (pok) mdl_ptr = int'(p);
            chk("busy_before_sr", busy, 1);
            bus_start();
        end
        bus_wbyte({DEV, 1'b1}, a);
        chk("rd_addr_ack", a, 1);
        chk("busy_in_read", busy, 1);
        for (int k = 0; k < n; k++) begin
            bus_rbyte(k < n - 1, b);
            rd_buf[k] = b;
            chk("rdata", b, mdl_regs[mdl_ptr]);
            chk("busy_in_read", busy, 1);
            if (k < n - 1) mdl_ptr = wrap(mdl_ptr);
        end
        bus_stop();
        finish_txn();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a, s;
        logic [7:0] ab;
        int         kind;

        for (int i = 0; i < NREG; i++) mdl_regs[i] = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        stable = 1'b1;
        sweep_loc();

        // Write 0x11,0x22 at pointer 3
        do_write({DEV, 1'b0}, 8'h03, 2, 8'h11, 8'h22, 8'h00);
        loc_chk("t_write_reg4", 4, 8'h22);
        loc_chk("t_write_reg3", 3, 8'h11);

        // Pointer write, repeated START, read two bytes (ACK then NACK)
        do_read(1'b1, 8'h03, 2);
        chk("t_read_b0", rd_buf[0], 8'h11);
        chk("t_read_b1", rd_buf[1], 8'h22);

        // Out-of-range pointer: NACK, no write, pointer stays at 4
        do_write({DEV, 1'b0}, 8'h10, 1, 8'h5A, 8'h00, 8'h00);
        do_read(1'b0, 8'h00, 1);
        chk("t_oor_ptr_kept", rd_buf[0], 8'h22);

        // Address mismatch
        do_write(8'hB0, 8'h03, 1, 8'h55, 8'h00, 8'h00);
        loc_chk("t_mismatch_reg3", 3, 8'h11);

        // Pointer wrap
        do_write({DEV, 1'b0}, 8'h0F, 3, 8'hAA, 8'hBB, 8'hCC);
        loc_chk("t_wrap_reg15", 15, 8'hAA);
        loc_chk("t_wrap_reg0", 0, 8'hBB);
        loc_chk("t_wrap_reg1", 1, 8'hCC);

        // Randomised transactions
        for (int t = 0; t < 25; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1: do_write({DEV, 1'b0}, 8'($urandom_range(0, 18)), $urandom_range(0, 3),
                               8'($urandom), 8'($urandom), 8'($urandom));
                2: do_read(1'b1, 8'($urandom_range(0, 15)), $urandom_range(1, 3));
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        do_read(1'b0, 8'h00, $urandom_range(1, 3));
                    end else begin
                        ab = 8'($urandom);
                        if (ab[7:1] == DEV) ab[7] = ~ab[7];
                        do_write(ab, 8'($urandom), 1, 8'($urandom), 8'h00, 8'h00);
                    end
                end
            endcase
        end

        // Reset during the 5th data bit of a read of an all-zero register
        do_write({DEV, 1'b0}, 8'h07, 1, 8'h00, 8'h00, 8'h00);
        do_write({DEV, 1'b0}, 8'h07, 0, 8'h00, 8'h00, 8'h00);
        stable = 1'b0;
        bus_start();
        bus_wbyte({DEV, 1'b1}, a);
        chk("abort_addr_ack", a, 1);
        for (int k = 0; k < 4; k++) begin
            bus_bit(1'b1, s);
            chk("abort_bit", s, 0);
        end
        repeat (Q) @(negedge clk);
        chk("abort_oe_before_rst", sda_oe, 1);
        rst = 1'b1;
        #1;
        chk("abort_oe_async", sda_oe, 0);
        repeat (3) @(negedge clk);
        chk("abort_busy_in_rst", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) mdl_regs[i] = 8'h00;
        mdl_ptr = 0;
        q_addr.delete();
        q_data.delete();
        bus_stop();
        finish_txn();
        loc_chk("abort_reg3_cleared", 3, 8'h00);
        do_read(1'b0, 8'h00, 1);
        chk("abort_read_zero", rd_buf[0], 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
